random_fetch_master: RTL and testbench

//  Bus initiator that reads the memory-mapped pseudo-random number device (device

---
 rtl/random_fetch_master_if.sv | 10 +
 rtl/random_fetch_master.sv | 138 +++++++++++++
 tb/tb_random_fetch_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/random_fetch_master_if.sv
// Arbitration handshake and read-data lines between the PRNG fetch master and the shared bus.
// The master drives bus_req and samples bus_gnt/data; the slave side is the arbiter plus device.
interface random_fetch_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [63:0] data;

  modport master (output bus_req, input bus_gnt, input data);
  modport slave  (input bus_req, output bus_gnt, output data);
endinterface

// File: rtl/random_fetch_master.sv
// Bus master that reads the PRNG device into a small FIFO for local consumers.
// Optional build macro RANDOM_WHITEN_EN: each stored word is XORed with the rotated previous raw sample.
module random_fetch_master #(
  parameter logic [7:0]  PRNG_ADDR = 8'b0000_0110,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_BURST = 2
) (
  input  logic                      procClock,
  input  logic                      procReset_n,
  input  logic                      enable,
  random_fetch_master_if.master     bus,
  output wire  [63:0]               address,
  output wire                       read,
  output wire                       write,
  output logic                      rd_valid,
  output logic [63:0]               rd_data,
  input  logic                      pop,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned BURST_W   = $clog2(MAX_BURST) + 1;
  localparam logic [63:0] READ_ADDR = {PRNG_ADDR, 56'd0};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_READ} state_t;

  state_t               r_state;
  logic                 r_bus_req;
  logic                 r_drive;
  logic [BURST_W-1:0]   r_burst;
  logic [63:0]          r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_valid;

  logic                 w_push;
  logic                 w_pop;
  logic [LVL_W-1:0]     w_level_nxt;
  logic                 w_more;
  logic [63:0]          w_store;

  assign w_push      = (r_state == S_READ);
  assign w_pop       = pop && (r_level != '0);
  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
  assign w_more      = bus.bus_gnt && enable
                       && ((32'(r_burst) + 32'd1) < MAX_BURST)
                       && (32'(w_level_nxt) < DEPTH);

`ifdef RANDOM_WHITEN_EN
  logic [63:0] r_prev;

  // Previous raw sample, rotated left by one, whitens the next stored word.
  assign w_store = bus.data ^ {r_prev[62:0], r_prev[63]};

  always_ff @(posedge procClock or negedge procReset_n) begin
    if (!procReset_n) begin
      r_prev <= '0;
    end else if (w_push) begin
      r_prev <= bus.data;
    end
  end
`else
  assign w_store = bus.data;
`endif

  // Request / read sequencing; r_drive enables the tri-state bus pins only in S_READ.
  always_ff @(posedge procClock or negedge procReset_n) begin
    if (!procReset_n) begin
      r_state   <= S_IDLE;
      r_bus_req <= 1'b0;
      r_drive   <= 1'b0;
      r_burst   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable && (32'(r_level) < DEPTH)) begin
            r_state   <= S_REQ;
            r_bus_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
          end else if (bus.bus_gnt) begin
            r_state <= S_READ;
            r_drive <= 1'b1;
            r_burst <= '0;
          end
        end
        S_READ: begin
          if (w_more) begin
            r_burst <= r_burst + BURST_W'(1);
          end else begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
            r_drive   <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
          r_drive   <= 1'b0;
        end
      endcase
    end
  end

  // Circular FIFO; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge procClock or negedge procReset_n) begin
    if (!procReset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_store;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
    end
  end

  assign bus.bus_req = r_bus_req;
  assign address     = r_drive ? READ_ADDR : 64'bz;
  assign read        = r_drive ? 1'b1      : 1'bz;
  assign write       = r_drive ? 1'b0      : 1'bz;
  assign rd_valid    = r_valid;
  assign rd_data     = r_mem[r_rd_ptr];
  assign level       = r_level;

endmodule

// File: tb/tb_random_fetch_master.sv
// Self-checking bench for random_fetch_master: directed vector table, corner sequences, randomized run.
// The FIFO reference is a plain queue; bus rules are checked from the observed read strobe.
module tb_random_fetch_master;

  localparam int          DEPTH     = 4;
  localparam int          MAX_BURST = 2;
  localparam logic [7:0]  PRNG_ADDR = 8'b0000_0110;
  localparam logic [63:0] RD_ADDR   = {PRNG_ADDR, 56'd0};

  logic        procClock = 1'b0;
  logic        procReset_n;
  logic        enable;
  logic        pop;
  wire  [63:0] address;
  wire         read;
  wire         write;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic [2:0]  level;

  random_fetch_master_if bus_if ();

  random_fetch_master #(
    .PRNG_ADDR (PRNG_ADDR),
    .DEPTH     (DEPTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .procClock   (procClock),
    .procReset_n (procReset_n),
    .enable      (enable),
    .bus         (bus_if),
    .address     (address),
    .read        (read),
    .write       (write),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .pop         (pop),
    .level       (level)
  );

  initial forever #5 procClock = ~procClock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: expected FIFO contents and what the bus rules predict for the next cycle.
  logic [63:0] q[$];
  logic [63:0] dev_q[$];
  int          run;
  bit          m_known, m_cont, m_start_ok, m_prev_rd;
  logic [63:0] m_prev;

  typedef struct {
    logic en, g, p;
    int   lvl;
    logic vld, req, rd;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, g, p, input int lvl, input logic vld, req, rd);
    vecs.push_back('{en, g, p, lvl, vld, req, rd});
  endfunction

  function automatic void model_reset();
    q.delete();
    run        = 0;
    m_known    = 1'b0;
    m_cont     = 1'b0;
    m_start_ok = 1'b0;
    m_prev_rd  = 1'b0;
    m_prev     = '0;
  endfunction

  // Apply inputs after the active edge, check at the falling edge, act as the device, advance the model.
  task automatic drive_check(input logic en, g, p, output bit rd_act);
    logic [63:0] raw, w;
    enable         = en;
    bus_if.bus_gnt = g;
    pop            = p;
    @(negedge procClock);
    chk("level",    64'(level),    64'(q.size()));
    chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("rd_data", rd_data, q[0]);
    rd_act = (read === 1'b1);
    if (rd_act) begin
      chk("req_in_read", 64'(bus_if.bus_req), 64'd1);
      chk("address",     address, RD_ADDR);
      chk("write_low",   64'(write === 1'b0), 64'd1);
    end else begin
      chk("addr_released", 64'(address === RD_ADDR), 64'd0);
    end
    if (m_known) chk("burst_continue", 64'(rd_act), 64'(m_cont));
    else if (rd_act) chk("read_start_ok", 64'(m_start_ok), 64'd1);
    if (m_prev_rd && !rd_act) chk("bus_released", 64'(bus_if.bus_req), 64'd0);
    if (rd_act && !m_prev_rd) chk("read_not_full", 64'(q.size() < DEPTH), 64'd1);

    if (rd_act) raw = (dev_q.size() != 0) ? dev_q.pop_front() : {$urandom, $urandom};
    else        raw = {$urandom, $urandom};
    bus_if.data = raw;

    if (p && q.size() != 0) void'(q.pop_front());
    if (rd_act) begin
`ifdef RANDOM_WHITEN_EN
      w      = raw ^ {m_prev[62:0], m_prev[63]};
      m_prev = raw;
`else
      w = raw;
`endif
      q.push_back(w);
      run     = m_prev_rd ? run + 1 : 1;
      m_known = 1'b1;
      m_cont  = g && en && (run < MAX_BURST) && (q.size() < DEPTH);
    end else begin
      run     = 0;
      m_known = 1'b0;
    end
    m_start_ok = g && en;
    m_prev_rd  = rd_act;
  endtask

  task automatic next_edge();
    @(posedge procClock);
    #1;
  endtask

  initial begin
    bit rd;
    bit seen;
    procReset_n    = 1'b0;
    enable         = 1'b0;
    pop            = 1'b0;
    bus_if.bus_gnt = 1'b0;
    bus_if.data    = '0;
    model_reset();

    // Fill A..D in two bursts, pop once, refill E; then grant withheld, grant dropped in READ, enable dropped in REQ.
    add(1,1,0, 0,0,0,0); add(1,1,0, 0,0,1,0); add(1,1,0, 0,0,1,1); add(1,1,0, 1,1,1,1);
    add(1,1,0, 2,1,0,0); add(1,1,0, 2,1,1,0); add(1,1,0, 2,1,1,1); add(1,1,0, 3,1,1,1);
    add(1,1,0, 4,1,0,0); add(1,1,1, 4,1,0,0); add(1,1,0, 3,1,0,0); add(1,1,0, 3,1,1,0);
    add(1,1,0, 3,1,1,1); add(1,0,1, 4,1,0,0); add(1,0,1, 3,1,0,0); add(1,0,1, 2,1,1,0);
    for (int i = 0; i < 10; i++) add(1,0,0, 1,1,1,0);
    add(1,1,0, 1,1,1,0); add(1,0,0, 1,1,1,1); add(1,0,0, 2,1,0,0); add(0,0,0, 2,1,1,0);
    add(0,0,0, 2,1,0,0);

    for (int i = 0; i < 6; i++) dev_q.push_back(64'hA5A5_0000_0000_0000 + 64'(i) * 64'h1111_0000_0101);

    repeat (2) @(posedge procClock);
    #1;
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_level",   64'(level), 64'd0);
    chk("reset_req",     64'(bus_if.bus_req), 64'd0);
    procReset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_check(vecs[i].en, vecs[i].g, vecs[i].p, rd);
      chk($sformatf("vec%0d_level", i), 64'(level),          64'(vecs[i].lvl));
      chk($sformatf("vec%0d_valid", i), 64'(rd_valid),       64'(vecs[i].vld));
      chk($sformatf("vec%0d_req", i),   64'(bus_if.bus_req), 64'(vecs[i].req));
      chk($sformatf("vec%0d_read", i),  64'(rd),             64'(vecs[i].rd));
      next_edge();
    end

    // Reset while a read is on the bus: pins release at once and the sample is dropped.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_check(1, 1, 0, rd);
      if (rd) seen = 1'b1;
      else next_edge();
    end
    chk("reset_mid_read_reached", 64'(seen), 64'd1);
    procReset_n = 1'b0;
    #1;
    chk("rst_read_released", 64'(read === 1'b1),      64'd0);
    chk("rst_addr_released", 64'(address === RD_ADDR), 64'd0);
    chk("rst_level",         64'(level),              64'd0);
    chk("rst_valid",         64'(rd_valid),           64'd0);
    chk("rst_req",           64'(bus_if.bus_req),     64'd0);
    model_reset();
    next_edge();
    procReset_n = 1'b1;

`ifdef RANDOM_WHITEN_EN
    // Two raw samples of 1: first stored as 1, second as 1 ^ rotl(1) = 3.
    dev_q.delete();
    dev_q.push_back(64'h1);
    dev_q.push_back(64'h1);
    repeat (5) begin
      drive_check(1, 1, 0, rd);
      next_edge();
    end
    drive_check(0, 0, 1, rd);
    chk("whiten_first", rd_data, 64'h1);
    next_edge();
    drive_check(0, 0, 0, rd);
    chk("whiten_second", rd_data, 64'h3);
    next_edge();
`endif

    dev_q.delete();
    for (int c = 0; c < 600; c++) begin
      drive_check(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 2) == 0), rd);
      next_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
